// File: rtl/data_mmu.sv
// data_mmu: translates load/store virtual addresses through an external TLB.
// The FSM runs IDLE -> LOOKUP -> RESP. The TLB flags are sampled on the edge
// that enters RESP. The response is registered and held until it is accepted
// or a flush arrives.
// Optional feature: define DATA_MMU_ALIGN_CHECK_EN to raise address-error
// exceptions for misaligned half/word accesses.
module data_mmu (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  output logic [18:0] tlb_vpn2_o,
  output logic        tlb_odd_o,
  input  logic [19:0] tlb_pfn_i,
  input  logic        tlb_found_i,
  input  logic        tlb_v_i,
  input  logic        tlb_d_i,
  input  logic        tlb_c_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_paddr_o,
  output logic        resp_cached_o,
  output logic        resp_exc_o,
  output logic [4:0]  resp_exccode_o,
  output logic        resp_refill_o,
  output logic [31:0] resp_badvaddr_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
`ifdef DATA_MMU_ALIGN_CHECK_EN
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
`endif

  state_t      state_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;

  logic        misalign;
  logic [31:0] paddr_d;
  logic        cached_d;
  logic        exc_d;
  logic [4:0]  exccode_d;
  logic        refill_d;
  logic [31:0] badvaddr_d;

  // The TLB port is fed straight from the latched address, so it holds
  // steady from LOOKUP until the next request is accepted.
  assign tlb_vpn2_o  = addr_q[31:13];
  assign tlb_odd_o   = addr_q[12];
  assign req_ready_o = rst && (state_q == IDLE) && !flush_i;

`ifdef DATA_MMU_ALIGN_CHECK_EN
  // Half accesses need addr[0]=0 and word accesses need addr[1:0]=0.
  always_comb begin
    misalign = 1'b0;
    case (size_q)
      2'd1:    misalign = addr_q[0];
      2'd2:    misalign = (addr_q[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  // The access size only matters to the alignment check.
  logic unused_size;
  assign unused_size = ^size_q;
  assign misalign    = 1'b0;
`endif

  // Prioritised exception decode and physical address formation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and infers a latch.
    exc_d      = 1'b0;
    exccode_d  = EXC_NONE;
    refill_d   = 1'b0;
    paddr_d    = {tlb_pfn_i, addr_q[11:0]};
    cached_d   = tlb_c_i;
    badvaddr_d = 32'd0;
`ifdef DATA_MMU_ALIGN_CHECK_EN
    if (misalign) begin
      exc_d     = 1'b1;
      exccode_d = we_q ? EXC_ADES : EXC_ADEL;
    end else
`endif
    if (!tlb_found_i) begin
      exc_d     = 1'b1;
      exccode_d = we_q ? EXC_TLBS : EXC_TLBL;
      refill_d  = 1'b1;
    end else if (!tlb_v_i) begin
      exc_d     = 1'b1;
      exccode_d = we_q ? EXC_TLBS : EXC_TLBL;
    end else if (we_q && !tlb_d_i) begin
      exc_d     = 1'b1;
      exccode_d = EXC_MOD;
    end
    if (exc_d) begin
      paddr_d    = 32'd0;
      cached_d   = 1'b0;
      badvaddr_d = addr_q;
    end
  end

  // Control FSM with registered response outputs. Flush overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // sees the values from before the edge, regardless of statement order.
    if (!rst) begin
      state_q         <= IDLE;
      addr_q          <= 32'd0;
      we_q            <= 1'b0;
      size_q          <= 2'd0;
      resp_valid_o    <= 1'b0;
      resp_paddr_o    <= 32'd0;
      resp_cached_o   <= 1'b0;
      resp_exc_o      <= 1'b0;
      resp_exccode_o  <= 5'd0;
      resp_refill_o   <= 1'b0;
      resp_badvaddr_o <= 32'd0;
    end else if (flush_i) begin
      state_q      <= IDLE;
      resp_valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_valid_o    <= 1'b1;
          resp_paddr_o    <= paddr_d;
          resp_cached_o   <= cached_d;
          resp_exc_o      <= exc_d;
          resp_exccode_o  <= exccode_d;
          resp_refill_o   <= refill_d;
          resp_badvaddr_o <= badvaddr_d;
          state_q         <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mmu.sv
// tb_data_mmu: directed self-checking bench for data_mmu.
module tb_data_mmu;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic [18:0] tlb_vpn2_o;
  logic        tlb_odd_o;
  logic [19:0] tlb_pfn_i;
  logic        tlb_found_i;
  logic        tlb_v_i;
  logic        tlb_d_i;
  logic        tlb_c_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_paddr_o;
  logic        resp_cached_o;
  logic        resp_exc_o;
  logic [4:0]  resp_exccode_o;
  logic        resp_refill_o;
  logic [31:0] resp_badvaddr_o;

  int checks = 0;
  int errors = 0;

  data_mmu dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_we_i        (req_we_i),
    .req_size_i      (req_size_i),
    .tlb_vpn2_o      (tlb_vpn2_o),
    .tlb_odd_o       (tlb_odd_o),
    .tlb_pfn_i       (tlb_pfn_i),
    .tlb_found_i     (tlb_found_i),
    .tlb_v_i         (tlb_v_i),
    .tlb_d_i         (tlb_d_i),
    .tlb_c_i         (tlb_c_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_paddr_o    (resp_paddr_o),
    .resp_cached_o   (resp_cached_o),
    .resp_exc_o      (resp_exc_o),
    .resp_exccode_o  (resp_exccode_o),
    .resp_refill_o   (resp_refill_o),
    .resp_badvaddr_o (resp_badvaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_tlb(input logic [19:0] pfn, input logic found, input logic v,
                         input logic d, input logic c);
    tlb_pfn_i   = pfn;
    tlb_found_i = found;
    tlb_v_i     = v;
    tlb_d_i     = d;
    tlb_c_i     = c;
  endtask

  // Issue a request and follow it into RESP, checking the fixed latency.
  // Called and returns #1 after a rising edge.
  task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_size_i  = size;
    check({tag, ":ready_idle"}, {31'd0, req_ready_o}, 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_addr_i  = 32'hDEAD_BEEF;
    req_we_i    = 1'b0;
    req_size_i  = 2'd0;
    check({tag, ":ready_lookup"}, {31'd0, req_ready_o}, 32'd0);
    check({tag, ":valid_lookup"}, {31'd0, resp_valid_o}, 32'd0);
    check({tag, ":vpn2"}, {13'd0, tlb_vpn2_o}, {13'd0, addr[31:13]});
    check({tag, ":odd"}, {31'd0, tlb_odd_o}, {31'd0, addr[12]});
    @(posedge clk); #1;
    check({tag, ":valid_resp"}, {31'd0, resp_valid_o}, 32'd1);
    check({tag, ":ready_resp"}, {31'd0, req_ready_o}, 32'd0);
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] paddr, input logic cached,
                             input logic exc, input logic [4:0] code, input logic refill,
                             input logic [31:0] bad);
    check({tag, ":paddr"}, resp_paddr_o, paddr);
    check({tag, ":cached"}, {31'd0, resp_cached_o}, {31'd0, cached});
    check({tag, ":exc"}, {31'd0, resp_exc_o}, {31'd0, exc});
    check({tag, ":exccode"}, {27'd0, resp_exccode_o}, {27'd0, code});
    check({tag, ":refill"}, {31'd0, resp_refill_o}, {31'd0, refill});
    check({tag, ":badvaddr"}, resp_badvaddr_o, bad);
  endtask

  task automatic accept_resp(input string tag);
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    check({tag, ":valid_after"}, {31'd0, resp_valid_o}, 32'd0);
    check({tag, ":ready_after"}, {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    rst          = 1'b0;
    flush_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = 32'd0;
    req_we_i     = 1'b0;
    req_size_i   = 2'd0;
    resp_ready_i = 1'b0;
    set_tlb(20'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst:req_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst:resp_valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst:vpn2", {13'd0, tlb_vpn2_o}, 32'd0);
    check("rst:odd", {31'd0, tlb_odd_o}, 32'd0);
    check("rst:paddr", resp_paddr_o, 32'd0);
    check("rst:badvaddr", resp_badvaddr_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Translated load
    set_tlb(20'h1F001, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("ld_ok", 1'b0, 32'h0040_1234, 2'd2);
    check("ld_ok:vpn2_val", {13'd0, tlb_vpn2_o}, 32'h0000_0200);
    check("ld_ok:odd_val", {31'd0, tlb_odd_o}, 32'd1);
    expect_resp("ld_ok", 32'h1F00_1234, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    accept_resp("ld_ok");

    // Store to a clean page raises Mod; cached forced low despite tlb_c
    set_tlb(20'h12345, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("st_mod", 1'b1, 32'h0080_2000, 2'd2);
    expect_resp("st_mod", 32'd0, 1'b0, 1'b1, 5'd1, 1'b0, 32'h0080_2000);
    accept_resp("st_mod");

    // Load miss -> refill
    set_tlb(20'h00042, 1'b0, 1'b1, 1'b1, 1'b1);
    issue("ld_miss", 1'b0, 32'h7FFF_F000, 2'd2);
    expect_resp("ld_miss", 32'd0, 1'b0, 1'b1, 5'd2, 1'b1, 32'h7FFF_F000);
    accept_resp("ld_miss");

    // Load invalid -> TLBL without refill
    set_tlb(20'h00042, 1'b1, 1'b0, 1'b1, 1'b1);
    issue("ld_inv", 1'b0, 32'h7FFF_F000, 2'd2);
    expect_resp("ld_inv", 32'd0, 1'b0, 1'b1, 5'd2, 1'b0, 32'h7FFF_F000);
    accept_resp("ld_inv");

    // Store miss -> TLBS with refill (miss outranks dirty)
    set_tlb(20'h00042, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("st_miss", 1'b1, 32'h0000_5004, 2'd2);
    expect_resp("st_miss", 32'd0, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0000_5004);
    accept_resp("st_miss");

    // Store to dirty page translates; uncached
    set_tlb(20'hABCDE, 1'b1, 1'b1, 1'b1, 1'b0);
    issue("st_ok", 1'b1, 32'hC000_0FFC, 2'd2);
    expect_resp("st_ok", 32'hABCD_EFFC, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    accept_resp("st_ok");

    // Response held while resp_ready low; flush in the third RESP cycle
    set_tlb(20'h0BEEF, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("hold", 1'b0, 32'h1000_0ABC, 2'd2);
    expect_resp("hold_c1", 32'h0BEE_FABC, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("hold_c2:valid", {31'd0, resp_valid_o}, 32'd1);
    expect_resp("hold_c2", 32'h0BEE_FABC, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("hold_c3:valid", {31'd0, resp_valid_o}, 32'd1);
    expect_resp("hold_c3", 32'h0BEE_FABC, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    flush_i      = 1'b1;
    resp_ready_i = 1'b1;
    #1;
    check("flush:ready_low", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    flush_i      = 1'b0;
    resp_ready_i = 1'b0;
    #1;
    check("flush:valid", {31'd0, resp_valid_o}, 32'd0);
    check("flush:ready_idle", {31'd0, req_ready_o}, 32'd1);

    // Flush in IDLE blocks a simultaneous request
    req_valid_i = 1'b1;
    req_addr_i  = 32'hFFFF_E000;
    flush_i     = 1'b1;
    #1;
    check("flush_idle:ready", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    #1;
    check("flush_idle:not_accepted", {31'd0, req_ready_o}, 32'd1);
    check("flush_idle:vpn2_kept", {13'd0, tlb_vpn2_o}, {13'd0, 19'h08000});
    @(posedge clk); #1;

    // Misaligned word store, then misaligned half load that also misses
    set_tlb(20'h00ABC, 1'b1, 1'b1, 1'b1, 1'b1);
    issue("st_word102", 1'b1, 32'h0000_0102, 2'd2);
`ifdef DATA_MMU_ALIGN_CHECK_EN
    expect_resp("st_word102", 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0000_0102);
`else
    expect_resp("st_word102", 32'h00AB_C102, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
`endif
    accept_resp("st_word102");

    set_tlb(20'h00ABC, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("ld_half1", 1'b0, 32'h0000_0001, 2'd1);
`ifdef DATA_MMU_ALIGN_CHECK_EN
    expect_resp("ld_half1", 32'd0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0000_0001);
`else
    expect_resp("ld_half1", 32'd0, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0000_0001);
`endif
    accept_resp("ld_half1");

    // Reset during LOOKUP discards the request
    set_tlb(20'h55555, 1'b1, 1'b1, 1'b1, 1'b1);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h2000_3000;
    req_size_i  = 2'd2;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rst_lk:in_lookup", {31'd0, req_ready_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_lk:valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst_lk:ready_in_rst", {31'd0, req_ready_o}, 32'd0);
    check("rst_lk:vpn2", {13'd0, tlb_vpn2_o}, 32'd0);
    @(posedge clk); #1;
    check("rst_lk:no_resp", {31'd0, resp_valid_o}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_lk:ready_idle", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk); #1;

    issue("post_rst", 1'b0, 32'h2000_3456, 2'd2);
    expect_resp("post_rst", 32'h5555_5456, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    accept_resp("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mmu.md
DATA_MMU -- requirements
Module: data_mmu

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 flush  input  1  pipeline flush; aborts any in-flight translation.
REQ-004 req_valid  input  1  load/store translation request.
REQ-005 req_ready  output  1  high only in IDLE with flush low.
REQ-006 req_addr  input  32  virtual address.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-009 tlb_vpn2 / tlb_odd  output  19 / 1  latched vaddr[31:13] / vaddr[12], driven to the TLB data port.
REQ-010 tlb_pfn  input  20  combinational PFN from the TLB; already handles unmapped segments.
REQ-011 tlb_found, tlb_v, tlb_d, tlb_c  input  1 each  TLB flags, registered one cycle after tlb_vpn2 is presented.
REQ-012 resp_valid  output  1  translation result available.
REQ-013 resp_ready  input  1  consumer accepts the result.
REQ-014 resp_paddr  output  32  physical address.
REQ-015 resp_cached  output  1  cacheable access.
REQ-016 resp_exc  output  1  exception flag.
REQ-017 resp_exccode  output  5  exception code.
REQ-018 resp_refill  output  1  1 = TLB refill; selects the refill vector.
REQ-019 resp_badvaddr  output  32  faulting virtual address.

Function
REQ-020 FSM states: IDLE, LOOKUP, RESP.
REQ-021 IDLE: on req_valid & req_ready, latch addr/we/size and go to LOOKUP.
REQ-022 tlb_vpn2/tlb_odd come from the latched address and hold steady from LOOKUP until the next accept.
REQ-023 LOOKUP lasts exactly one cycle, then the FSM goes to RESP; the flag inputs are sampled on entry to RESP.
REQ-024 RESP: resp_valid=1, all resp_* outputs held stable; go to IDLE when resp_ready=1.
REQ-025 Latency: accept at edge N gives resp_valid=1 from cycle N+2; back-to-back throughput is one request per 3 cycles.
REQ-026 Exception priority, highest first: alignment error (REQ-035), !tlb_found, !tlb_v, (we & !tlb_d).
REQ-027 !tlb_found: exccode = 2 for a load, 3 for a store; refill = 1.
REQ-028 !tlb_v: same exccode as REQ-027; refill = 0.
REQ-029 Store with !tlb_d: exccode = 1 (Mod); refill = 0.
REQ-030 No exception: paddr = {tlb_pfn, vaddr[11:0]}, cached = tlb_c, exc = 0, exccode = 0, badvaddr = 0.
REQ-031 Any exception: exc = 1, badvaddr = latched vaddr, paddr = 0, cached = 0.
REQ-032 flush high in any state: next state IDLE, resp_valid = 0, no request accepted in that cycle; flush wins over a simultaneous req_valid or resp_ready.
REQ-033 No request is accepted while in LOOKUP or RESP.

Reset
REQ-034 rst=0 at an edge: state = IDLE, latched fields = 0, all outputs 0 (req_ready = 0 during reset), tlb_vpn2 = 0, tlb_odd = 0. A reset mid-operation discards the request.

Configuration
REQ-035 DATA_MMU_ALIGN_CHECK_EN defined: misalignment raises an exception with exccode 4 (load) or 5 (store), refill = 0, badvaddr = vaddr. Misalignment means half with addr[0]=1, or word with addr[1:0]≠0. The TLB flags are ignored for that request. Not defined: no alignment check; exceptions come from TLB outcomes only.

Verification
REQ-036 Load 0x0040_1234, TLB pfn=0x1F001, found=v=c=1 -> resp at N+2: paddr=0x1F00_1234, cached=1, exc=0.
REQ-037 Store 0x0080_2000, found=1, v=1, d=0 -> exc=1, exccode=1, refill=0, badvaddr=0x0080_2000.
REQ-038 Load 0x7FFF_F000, found=0 -> exccode=2, refill=1. Same address with found=1, v=0 -> exccode=2, refill=0.
REQ-039 resp_ready held low 5 cycles, flush asserted in cycle 3 -> outputs stable until flush; resp_valid=0 next cycle; req_ready=1 in IDLE after.
REQ-040 With DATA_MMU_ALIGN_CHECK_EN: word store to 0x0000_0102 -> exccode=5, badvaddr=0x0000_0102. Without it: translated normally.
REQ-041 rst=0 asserted during LOOKUP -> next cycle IDLE, resp_valid=0; a new request is accepted normally after rst=1.
